// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter sequencer for a simple in-order core.
// Owns the PC, the trap return address (epc), the latched trap cause and the
// in-trap flag, and walks a four-state FSM (RUN / FLUSH / HALT / FAULT).
//
// Handshake: there is no valid/ready pairing on this block. Every control
// input is a level sampled on the rising clk edge. fetch_valid is a registered
// qualifier: the instruction memory word at pc is meaningful only while
// fetch_valid is 1. No output depends combinationally on any input.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] TRAP_VEC = 16'h0100,
  parameter int          IM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        trap_req,
  input  logic [3:0]  trap_cause,
  input  logic        uret,
  input  logic        epc_we,
  input  logic [15:0] epc_wdata,
  input  logic        halt_req,
  input  logic        resume,
  output logic [15:0] pc,
  output logic        fetch_valid,
  output logic [15:0] epc,
  output logic [3:0]  cause,
  output logic        in_trap,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // Instruction memory size in bytes; 17 bits so the compare never wraps.
  localparam logic [16:0] IM_BYTES = 17'(IM_WORDS * 4);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] epc_q, epc_d;
  logic [3:0]  cause_q, cause_d;
  logic        in_trap_q, in_trap_d;

  logic        pc_in_range;
  logic        trap_take;
  logic        trap_capture;
  logic [3:0]  trap_code;

  assign pc_in_range = ({1'b0, pc_q} < IM_BYTES);

  // State register: FSM state plus all architectural fetch state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      pc_q      <= RESET_PC;
      epc_q     <= 16'h0000;
      cause_q   <= 4'd0;
      in_trap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      in_trap_q <= in_trap_d;
    end
  end

  // Next-state logic: event priority in RUN is
  // out-of-range > trap_req > uret > redirect > halt_req > stall > increment.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cause_d      = cause_q;
    in_trap_d    = in_trap_q;
    trap_take    = 1'b0;
    trap_code    = 4'd0;
    trap_capture = 1'b0;

    case (state_q)
      S_RUN: begin
        if (!pc_in_range) begin
          // No instruction exists at pc, so nothing else can be honoured.
          state_d = S_FAULT;
        end else if (trap_req) begin
          trap_take = 1'b1;
          trap_code = trap_cause;
        end else if (uret) begin
          if (in_trap_q) begin
            pc_d      = epc_q;
            in_trap_d = 1'b0;
            state_d   = S_FLUSH;
          end else begin
            // Return outside a handler is an illegal instruction.
            trap_take = 1'b1;
            trap_code = 4'd2;
          end
        end else if (redirect) begin
          if (redirect_pc[1:0] == 2'b00) begin
            pc_d    = redirect_pc;
            state_d = S_FLUSH;
          end else begin
            // Misaligned target.
            trap_take = 1'b1;
            trap_code = 4'd0;
          end
        end else if (halt_req) begin
          state_d = S_HALT;
        end else if (!stall) begin
          pc_d = pc_q + 16'd4;
        end
      end
      S_FLUSH: begin
        state_d = S_RUN;
      end
      S_HALT: begin
        if (resume) begin
          state_d = S_RUN;
          pc_d    = pc_q + 16'd4;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    // A trap inside a handler is a double fault: freeze, keep epc/cause.
    if (trap_take) begin
      if (in_trap_q) begin
        state_d = S_FAULT;
        pc_d    = pc_q;
      end else begin
        trap_capture = 1'b1;
        pc_d         = TRAP_VEC;
        cause_d      = trap_code;
        in_trap_d    = 1'b1;
        state_d      = S_FLUSH;
      end
    end

    // Trap capture of epc wins over a same-edge CSR write.
    if (trap_capture) begin
      epc_d = pc_q;
    end else if (epc_we) begin
      epc_d = epc_wdata;
    end else begin
      epc_d = epc_q;
    end
  end

  // Output decode: purely from registered state.
  always_comb begin
    pc          = pc_q;
    epc         = epc_q;
    cause       = cause_q;
    in_trap     = in_trap_q;
    state       = state_q;
    fetch_valid = (state_q == S_RUN) && pc_in_range;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the first fetch address after reset.
REQ-002 Parameter TRAP_VEC, default 16'h0100, is the trap handler entry address (instruction word 64).
REQ-003 Parameter IM_WORDS, default 128, is the instruction memory depth in 32-bit words.
REQ-004 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  is the reset: asynchronous, active-low.
REQ-006 stall  input  1  holds the PC when high.
REQ-007 redirect  input  1  requests a branch or jump to redirect_pc.
REQ-008 redirect_pc  input  16  is the branch or jump target byte address.
REQ-009 trap_req  input  1  signals an exception on the current instruction.
REQ-010 trap_cause  input  4  is the cause code accompanying trap_req.
REQ-011 uret  input  1  requests a return from trap.
REQ-012 epc_we  input  1  is the CSR write strobe for epc.
REQ-013 epc_wdata  input  16  is the CSR write data for epc.
REQ-014 halt_req  input  1  signals an ecall with exit code (x17=10).
REQ-015 resume  input  1  leaves the HALT state.
REQ-016 pc  output  16  is the byte address driven to instruction memory.
REQ-017 fetch_valid  output  1  qualifies the instruction at pc.
REQ-018 epc  output  16  is the saved trap return address.
REQ-019 cause  output  4  is the latched trap cause.
REQ-020 in_trap  output  1  is high while the handler executes.
REQ-021 state  output  2  encodes the FSM state: RUN=0, FLUSH=1, HALT=2, FAULT=3.

Function
REQ-022 The FSM SHALL have four states, RUN, FLUSH, HALT and FAULT, registered on clk.
REQ-023 In RUN, at each edge the SHALL-priority for updates is: trap_req > uret > redirect > halt_req > stall > pc<=pc+4 (16-bit add, wrapping).
REQ-024 On trap_req in RUN with in_trap=0: epc<=pc, cause<=trap_cause, in_trap<=1, pc<=TRAP_VEC, and the next state is FLUSH.
REQ-025 On trap_req in RUN with in_trap=1 (double fault): the next state is FAULT, pc holds, and epc and cause are unchanged.
REQ-026 On uret in RUN: pc<=epc, in_trap<=0, and the next state is FLUSH; uret with in_trap=0 is treated as trap_req with cause 4'd2 (illegal instruction).
REQ-027 On redirect in RUN: if redirect_pc[1:0]==0, pc<=redirect_pc and the next state is FLUSH; otherwise a trap with cause 4'd0 (misaligned) is taken per REQ-024 and REQ-025.
REQ-028 On halt_req in RUN: pc holds and the next state is HALT.
REQ-029 In FLUSH, fetch_valid=0 for exactly one cycle, pc holds, and the next state is RUN; all inputs except epc_we are ignored.
REQ-030 In HALT, pc holds and fetch_valid=0; resume returns to RUN with pc<=pc+4.
REQ-031 In FAULT, pc holds and fetch_valid=0; only reset exits this state.
REQ-032 fetch_valid SHALL be 1 only in RUN with pc < IM_WORDS*4.
REQ-033 When pc >= IM_WORDS*4 in RUN, the next state is FAULT, regardless of stall.
REQ-034 When epc_we=1, epc<=epc_wdata in any state, unless the same edge captures a trap, in which case the trap capture wins.
REQ-035 stall SHALL NOT block trap_req, uret or redirect; stall only suppresses the increment.
REQ-036 All outputs SHALL be registered or decoded from registered state only, with no combinational input-to-output path.

Reset
REQ-037 While rst_n=0: pc=RESET_PC, epc=0, cause=0, in_trap=0, state=RUN, and fetch_valid=1 once pc is in range.
REQ-038 Reset asserted mid-trap or mid-FLUSH SHALL clear all state immediately, without waiting for clk.
REQ-039 The first increment SHALL occur on the first rising edge after rst_n deasserts.

Verification
REQ-040 Reset release, 5 idle cycles -> pc sequence 0,4,8,12,16,20, with fetch_valid=1 throughout.
REQ-041 At pc=12, trap_req=1 with cause=4'd5 -> epc=12, cause=5, pc=0x100, one FLUSH cycle with fetch_valid=0, then pc=0x104.
REQ-042 In the handler, epc_we=1 with epc_wdata=16 followed by uret -> pc=16, in_trap=0, one FLUSH cycle, then 20.
REQ-043 At pc=8, redirect with redirect_pc=0x0006 -> misaligned trap: epc=8, cause=0, pc=0x100; a second trap_req before uret -> state=FAULT, pc frozen.
REQ-044 With stall=1 and redirect=1 (target 0x20) in the same cycle -> pc=0x20; then stall=1 alone for 3 cycles -> pc holds at 0x20.
REQ-045 At pc=0x1FC, one increment -> pc=0x200, fetch_valid=0, state=FAULT; then pulse rst_n low asynchronously -> pc=0 immediately.
